// File: rtl/bcd_seg_display.sv
// bcd_seg_display: reaction-timer display stage.
// A binary result is converted to 8 BCD digits by a sequential double-dabble
// engine, latched, and scanned onto an 8-digit active-low 7-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).

module bcd_seg_display #(
    parameter int BIN_W    = 27,
    parameter int SCAN_DIV = 100000
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             busy,
    output logic             bcd_valid,
    output logic [31:0]      bcd_out,
    output logic             overflow,
    output logic [7:0]       AN,
    output logic [7:0]       SEG
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(99_999_999);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [BIN_W-1:0] shift_q;
    logic [31:0]      scratch_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_cap_q;
    logic             busy_q;
    logic             bcd_valid_q;
    logic [31:0]      bcd_out_q;
    logic             overflow_q;

    logic [31:0]      adj;
    logic [31:0]      scratch_shl;
    logic [BIN_W-1:0] shift_shl;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       digit;

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 8; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        {scratch_shl, shift_shl} = {adj, shift_q} << 1;
    end

    // Conversion FSM; bcd_out/overflow only change in DONE so partial results never show.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            ovf_cap_q   <= 1'b0;
            busy_q      <= 1'b0;
            bcd_valid_q <= 1'b0;
            bcd_out_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bin_valid) begin
                        if (bin_in > MAX_VAL) begin
                            shift_q   <= MAX_VAL;
                            ovf_cap_q <= 1'b1;
                        end else begin
                            shift_q   <= bin_in;
                            ovf_cap_q <= 1'b0;
                        end
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    scratch_q <= scratch_shl;
                    shift_q   <= shift_shl;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT)
                        state_q <= DONE;
                end
                DONE: begin
                    bcd_out_q   <= scratch_q;
                    overflow_q  <= ovf_cap_q;
                    bcd_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign bcd_valid = bcd_valid_q;
    assign bcd_out   = bcd_out_q;
    assign overflow  = overflow_q;

    // Scan divider, digit index and the next anode/segment pattern.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end

        an_d  = ~(8'b1 << idx_q);
        digit = bcd_out_q[{idx_q, 2'b00} +: 4];

        case (digit)
            4'd0:    seg_d = 8'b1100_0000;
            4'd1:    seg_d = 8'b1111_1001;
            4'd2:    seg_d = 8'b1010_0100;
            4'd3:    seg_d = 8'b1011_0000;
            4'd4:    seg_d = 8'b1001_1001;
            4'd5:    seg_d = 8'b1001_0010;
            4'd6:    seg_d = 8'b1000_0010;
            4'd7:    seg_d = 8'b1111_1000;
            4'd8:    seg_d = 8'b1000_0000;
            4'd9:    seg_d = 8'b1001_0000;
            default: seg_d = 8'hFF;
        endcase

        // Saturated value is flagged by the decimal point of the top digit.
        if (idx_q == 3'd7 && overflow_q)
            seg_d[7] = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and every digit above it are zero; digit 0 always lit.
        if (idx_q != 3'd0 && (bcd_out_q >> {idx_q, 2'b00}) == 32'd0)
            seg_d = 8'hFF;
`endif
    end

    // Registered scan outputs so AN and SEG switch on the same edge.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench for bcd_seg_display: each load pushes its expected
// {overflow, bcd_out} into a queue, and a monitor pops on every bcd_valid.

module tb_bcd_seg_display;

    localparam int BIN_W    = 27;
    localparam int SCAN_DIV = 4;

    logic             clk;
    logic             rst_n;
    logic [BIN_W-1:0] bin_in;
    logic             bin_valid;
    logic             busy;
    logic             bcd_valid;
    logic [31:0]      bcd_out;
    logic             overflow;
    logic [7:0]       an;
    logic [7:0]       seg;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_valid = 0;

    logic [32:0] sb_q[$];

    bcd_seg_display #(
        .BIN_W   (BIN_W),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .bin_in    (bin_in),
        .bin_valid (bin_valid),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd_out   (bcd_out),
        .overflow  (overflow),
        .AN        (an),
        .SEG       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every bcd_valid pulse must match the oldest outstanding expectation.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bcd_valid) begin
                n_valid++;
                if (sb_q.size() == 0) begin
                    check("unexpected_bcd_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("bcd_out", bcd_out, e[31:0]);
                    check("overflow", {31'd0, overflow}, {31'd0, e[32]});
                end
            end
        end
    end

    // Load v; optionally re-pulse bin_valid with another value at cycle glitch_at.
    task automatic run_conv(input logic [BIN_W-1:0] v, input logic [31:0] eb, input logic eo,
                            input int glitch_at);
        int k;
        int nv0;
        @(negedge clk);
        bin_in    = v;
        bin_valid = 1'b1;
        sb_q.push_back({eo, eb});
        nv0 = n_valid;
        k = -1;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            k++;
            #1;
            if (k == 0) begin
                bin_valid = 1'b0;
                check("busy_after_load", {31'd0, busy}, 32'd1);
            end
            if (k == glitch_at) begin
                bin_in    = 27'd4321;
                bin_valid = 1'b1;
            end
            if (k == glitch_at + 1)
                bin_valid = 1'b0;
            if (bcd_valid)
                break;
        end
        check("latency", k, 32'd28);
        repeat (3) @(negedge clk);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("valid_count", n_valid - nv0, 32'd1);
    endtask

    // Wait for the digit-7 slot and check its segment pattern.
    task automatic check_digit7(input logic [7:0] exp);
        logic found;
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (an == 8'h7F) begin
                found = 1'b1;
                break;
            end
        end
        if (found)
            check("seg_digit7", {24'd0, seg}, {24'd0, exp});
        else
            check("an7_seen", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] prev_an;
        logic       found;
        int         nv0;
        int         slot;
        logic [7:0] exp_seg;

        rst_n     = 1'b0;
        bin_in    = '0;
        bin_valid = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_an", {24'd0, an}, 32'h0000_00FF);
        check("rst_seg", {24'd0, seg}, 32'h0000_00FF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bcd_out", bcd_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_an", {24'd0, an}, 32'h0000_00FE);
        check("first_seg", {24'd0, seg}, 32'h0000_00C0);
        check("first_bcd_out", bcd_out, 32'd0);
        check("first_ovf", {31'd0, overflow}, 32'd0);

        // Basic conversion
        run_conv(27'd1234, 32'h0000_1234, 1'b0, -1);

        // Largest in-range value, then saturation
        run_conv(27'd99_999_999, 32'h9999_9999, 1'b0, -1);
        check_digit7(8'h90);
        run_conv(27'd100_000_000, 32'h9999_9999, 1'b1, -1);
        check_digit7(8'h10);
        run_conv(27'd7, 32'h0000_0007, 1'b0, -1);

        // Load while busy is ignored
        run_conv(27'd5678, 32'h0000_5678, 1'b0, 5);

        // Reset mid-conversion aborts without a bcd_valid
        @(negedge clk);
        bin_in    = 27'd7777;
        bin_valid = 1'b1;
        @(negedge clk);
        bin_valid = 1'b0;
        nv0 = n_valid;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_an", {24'd0, an}, 32'h0000_00FF);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_valid", n_valid - nv0, 32'd0);
        check("abort_bcd_out", bcd_out, 32'd0);
        run_conv(27'd1234, 32'h0000_1234, 1'b0, -1);

        // Scan sequence with value 42
        run_conv(27'd42, 32'h0000_0042, 1'b0, -1);
        found   = 1'b0;
        prev_an = an;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (prev_an == 8'h7F && an == 8'hFE) begin
                found = 1'b1;
                break;
            end
            prev_an = an;
        end
        check("scan_wrap_seen", {31'd0, found}, 32'd1);
        if (found) begin
            for (int i = 0; i < 40; i++) begin
                if (i > 0)
                    @(negedge clk);
                slot = (i / 4) % 8;
                case (slot)
                    0:       exp_seg = 8'hA4;
                    1:       exp_seg = 8'h99;
`ifdef LEADING_ZERO_BLANK_EN
                    default: exp_seg = 8'hFF;
`else
                    default: exp_seg = 8'hC0;
`endif
                endcase
                check($sformatf("scan_an_%0d", i), {24'd0, an}, {24'd0, ~(8'b1 << slot)});
                check($sformatf("scan_seg_%0d", i), {24'd0, seg}, {24'd0, exp_seg});
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
